// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_ctrl
//  Purpose  : UART receive controller. Detects the start bit, drives the
//             oversampling data sampler (enable + per-bit edge counter), and
//             assembles the data bits LSB-first from the sampler's
//             majority-voted sampled_bit. It checks the optional parity bit
//             and the stop bit, then reports the frame with single-cycle
//             pulses.
//  Ports    : CLK          - system clock, rising edge
//             RST          - synchronous active-high reset
//             RX_IN        - synchronised serial line, idle high
//             Prescale     - oversampling ratio (8 or 16)
//             PAR_EN       - frame carries a parity bit
//             PAR_TYP      - 0 even / 1 odd parity
//             sampled_bit  - majority-voted bit from the data sampler
//             dat_samp_en  - data sampler enable (high outside IDLE)
//             edge_cnt     - oversampling tick index within the current bit
//             P_DATA       - last cleanly received word
//             data_valid   - pulse: clean frame received
//             par_err      - pulse: parity mismatch
//             stp_err      - pulse: stop bit sampled low
//             strt_glitch  - pulse: start bit rejected
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [4:0]            Prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  sampled_bit,
    output logic                  dat_samp_en,
    output logic [4:0]            edge_cnt,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  strt_glitch
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    localparam logic [3:0] c_LAST_BIT = 4'(DATA_WIDTH - 1);

    state_t                r_state;
    logic [4:0]            r_edge_cnt;
    logic [4:0]            r_prescale;
    logic                  r_par_en;
    logic                  r_par_typ;
    logic [3:0]            r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] r_p_data;
    logic                  r_par_mismatch;
    logic                  r_data_valid;
    logic                  r_par_err;
    logic                  r_stp_err;
    logic                  r_strt_glitch;

    // Frame settings are latched at start detect, so the bit-end tick uses
    // the latched ratio rather than the live input.
    logic w_bit_end;
    assign w_bit_end = (r_edge_cnt == (r_prescale - 5'd1));

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state        <= S_IDLE;
            r_edge_cnt     <= 5'd0;
            r_prescale     <= 5'd8;
            r_par_en       <= 1'b0;
            r_par_typ      <= 1'b0;
            r_bit_cnt      <= 4'd0;
            r_shift        <= '0;
            r_p_data       <= '0;
            r_par_mismatch <= 1'b0;
            r_data_valid   <= 1'b0;
            r_par_err      <= 1'b0;
            r_stp_err      <= 1'b0;
            r_strt_glitch  <= 1'b0;
        end else begin
            // Status outputs are single-cycle pulses.
            r_data_valid  <= 1'b0;
            r_par_err     <= 1'b0;
            r_stp_err     <= 1'b0;
            r_strt_glitch <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    r_edge_cnt <= 5'd0;
                    if (!RX_IN) begin
                        r_prescale     <= Prescale;
                        r_par_en       <= PAR_EN;
                        r_par_typ      <= PAR_TYP;
                        r_par_mismatch <= 1'b0;
                        r_bit_cnt      <= 4'd0;
                        r_state        <= S_START;
                    end
                end
                default: begin
                    if (w_bit_end) begin
                        r_edge_cnt <= 5'd0;
                        case (r_state)
                            S_START: begin
                                if (sampled_bit) begin
                                    r_strt_glitch <= 1'b1;
                                    r_state       <= S_IDLE;
                                end else begin
                                    r_bit_cnt <= 4'd0;
                                    r_state   <= S_DATA;
                                end
                            end
                            S_DATA: begin
                                // Shift right from the top so the first bit
                                // received ends in bit 0.
                                r_shift   <= {sampled_bit, r_shift[DATA_WIDTH-1:1]};
                                r_bit_cnt <= r_bit_cnt + 4'd1;
                                if (r_bit_cnt == c_LAST_BIT) begin
                                    r_state <= r_par_en ? S_PARITY : S_STOP;
                                end
                            end
                            S_PARITY: begin
                                r_par_mismatch <= sampled_bit != ((^r_shift) ^ r_par_typ);
                                r_state        <= S_STOP;
                            end
                            S_STOP: begin
                                r_state <= S_IDLE;
                                if (sampled_bit && !r_par_mismatch) begin
                                    r_data_valid <= 1'b1;
                                    r_p_data     <= r_shift;
                                end else begin
                                    r_stp_err <= ~sampled_bit;
                                    r_par_err <= r_par_mismatch;
                                end
                            end
                            default: r_state <= S_IDLE;
                        endcase
                    end else begin
                        r_edge_cnt <= r_edge_cnt + 5'd1;
                    end
                end
            endcase
        end
    end

    assign dat_samp_en = (r_state != S_IDLE);
    assign edge_cnt    = r_edge_cnt;
    assign P_DATA      = r_p_data;
    assign data_valid  = r_data_valid;
    assign par_err     = r_par_err;
    assign stp_err     = r_stp_err;
    assign strt_glitch = r_strt_glitch;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_ctrl
//  Purpose  : Self-checking bench for uart_rx_ctrl. Frames are driven as
//             bit-serial waveforms on RX_IN, with sampled_bit following the
//             current bit. Expected pulses are scheduled by cycle from the
//             frame-length arithmetic, and a per-cycle monitor compares
//             pulses, P_DATA, dat_samp_en and edge_cnt.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       RX_IN = 1'b1;
    logic [4:0] Prescale = 5'd8;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic       sampled_bit = 1'b1;
    logic       dat_samp_en;
    logic [4:0] edge_cnt;
    logic [7:0] P_DATA;
    logic       data_valid, par_err, stp_err, strt_glitch;

    always #5 CLK = ~CLK;

    uart_rx_ctrl #(.DATA_WIDTH(8)) dut (
        .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .Prescale(Prescale),
        .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .sampled_bit(sampled_bit),
        .dat_samp_en(dat_samp_en), .edge_cnt(edge_cnt), .P_DATA(P_DATA),
        .data_valid(data_valid), .par_err(par_err), .stp_err(stp_err),
        .strt_glitch(strt_glitch)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Expected pulse vector {data_valid, par_err, stp_err, strt_glitch} by cycle.
    logic [3:0] exp_pulse [int];
    logic [7:0] exp_data  [int];
    logic [7:0] exp_pdata = 8'h00;
    int busy_lo = 1;
    int busy_hi = 0;
    int cur_p   = 8;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d: got %0h want %0h", name, cyc, act, exp);
        end
    endtask

    // Per-cycle monitor, sampling 2ns after the rising edge.
    initial begin : mon
        logic [3:0] ep;
        logic       ee;
        logic [4:0] ec;
        forever begin
            @(posedge CLK);
            cyc++;
            #2;
            ep = exp_pulse.exists(cyc) ? exp_pulse[cyc] : 4'b0000;
            if (ep[3]) exp_pdata = exp_data[cyc];
            if (exp_pulse.exists(cyc)) exp_pulse.delete(cyc);
            ee = (cyc >= busy_lo) && (cyc <= busy_hi);
            ec = ee ? 5'((cyc - busy_lo) % cur_p) : 5'd0;
            chk("pulses", 32'({data_valid, par_err, stp_err, strt_glitch}), 32'(ep));
            chk("P_DATA", 32'(P_DATA), 32'(exp_pdata));
            chk("dat_samp_en", 32'(dat_samp_en), 32'(ee));
            chk("edge_cnt", 32'(edge_cnt), 32'(ec));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    // Drives one frame: gap idle cycles, then start-detect cycle T, then each
    // bit held for p cycles. Frame settings are scrambled after T.
    task automatic send_frame(input logic [7:0] d, input int p, input bit pen, input bit ptyp,
                              input bit badpar, input bit stopb, input int gap,
                              input bit edv, input bit epe, input bit ese);
        logic b [0:10];
        int   nb;
        int   t0;
        repeat (gap) begin
            @(negedge CLK);
            RX_IN = 1'b1; sampled_bit = 1'b1;
        end
        @(negedge CLK);
        RX_IN = 1'b0; sampled_bit = 1'b0;
        Prescale = 5'(p); PAR_EN = pen; PAR_TYP = ptyp;
        t0 = cyc;
        nb = pen ? 11 : 10;
        b[0] = 1'b0;
        for (int i = 0; i < 8; i++) b[i+1] = d[i];
        if (pen) b[9] = (^d) ^ ptyp ^ badpar;
        b[nb-1] = stopb;
        busy_lo = t0 + 1;
        busy_hi = t0 + p * nb;
        cur_p   = p;
        exp_pulse[t0 + 1 + p * nb] = {edv, epe, ese, 1'b0};
        if (edv) exp_data[t0 + 1 + p * nb] = d;
        for (int bi = 0; bi < nb; bi++) begin
            for (int t = 0; t < p; t++) begin
                @(negedge CLK);
                RX_IN = b[bi]; sampled_bit = b[bi];
                Prescale = ($urandom_range(0, 1) == 1) ? 5'd8 : 5'd16;
                PAR_EN   = 1'($urandom_range(0, 1));
                PAR_TYP  = 1'($urandom_range(0, 1));
            end
        end
    endtask

    typedef struct {
        logic [7:0] d;
        int         p;
        bit         pen, ptyp, badpar, stopb;
        int         gap;
        bit         dv, pe, se;
    } vec_t;

    vec_t vt [8];

    initial begin : stim
        int         t0;
        int         r;
        logic [7:0] d;
        int         p, gap;
        bit         pen, ptyp, badpar, stopb;

        vt[0] = '{8'hA5, 8,  1'b0, 1'b0, 1'b0, 1'b1, 2, 1'b1, 1'b0, 1'b0};
        vt[1] = '{8'h3C, 16, 1'b1, 1'b0, 1'b0, 1'b1, 2, 1'b1, 1'b0, 1'b0};
        vt[2] = '{8'h3C, 16, 1'b1, 1'b0, 1'b1, 1'b1, 2, 1'b0, 1'b1, 1'b0};
        vt[3] = '{8'h55, 8,  1'b0, 1'b0, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b1};
        vt[4] = '{8'h55, 8,  1'b1, 1'b1, 1'b1, 1'b0, 2, 1'b0, 1'b1, 1'b1};
        vt[5] = '{8'h81, 8,  1'b1, 1'b1, 1'b0, 1'b1, 3, 1'b1, 1'b0, 1'b0};
        vt[6] = '{8'h12, 16, 1'b0, 1'b0, 1'b0, 1'b1, 2, 1'b1, 1'b0, 1'b0};
        vt[7] = '{8'h34, 16, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0};

        repeat (3) @(negedge CLK);
        RST = 1'b0;
        chk("reset_en", 32'(dat_samp_en), 32'd0);
        chk("reset_pdata", 32'(P_DATA), 32'd0);

        for (int i = 0; i < 8; i++)
            send_frame(vt[i].d, vt[i].p, vt[i].pen, vt[i].ptyp, vt[i].badpar, vt[i].stopb,
                       vt[i].gap, vt[i].dv, vt[i].pe, vt[i].se);

        // Start glitch: line low two cycles, sampler reports 1 at START bit-end.
        repeat (3) begin @(negedge CLK); RX_IN = 1'b1; sampled_bit = 1'b1; end
        @(negedge CLK);
        RX_IN = 1'b0; sampled_bit = 1'b1; Prescale = 5'd8;
        t0 = cyc;
        busy_lo = t0 + 1; busy_hi = t0 + 8; cur_p = 8;
        exp_pulse[t0 + 9] = 4'b0001;
        for (int t = 1; t <= 8; t++) begin
            @(negedge CLK);
            RX_IN = (t < 2) ? 1'b0 : 1'b1; sampled_bit = 1'b1;
        end
        @(negedge CLK);
        chk("glitch_idle_en", 32'(dat_samp_en), 32'd0);
        chk("glitch_pulse", 32'(strt_glitch), 32'd1);

        // Reset during data bit 4 of a frame.
        repeat (2) @(negedge CLK);
        RX_IN = 1'b0; sampled_bit = 1'b0; Prescale = 5'd8; PAR_EN = 1'b0;
        t0 = cyc;
        busy_lo = t0 + 1; busy_hi = t0 + 200; cur_p = 8;
        d = 8'h5A;
        for (int n = 0; n < 8 * 5 + 3; n++) begin
            @(negedge CLK);
            r = n / 8;
            RX_IN = (r == 0) ? 1'b0 : d[r-1];
            sampled_bit = RX_IN;
        end
        @(negedge CLK);
        RST = 1'b1; RX_IN = 1'b1; sampled_bit = 1'b1;
        busy_hi = cyc;
        exp_pdata = 8'h00;
        @(negedge CLK);
        RST = 1'b0;
        chk("rst_mid_en", 32'(dat_samp_en), 32'd0);
        chk("rst_mid_edge", 32'(edge_cnt), 32'd0);
        chk("rst_mid_pulses", 32'({data_valid, par_err, stp_err, strt_glitch}), 32'd0);
        send_frame(8'hFF, 8, 1'b0, 1'b0, 1'b0, 1'b1, 2, 1'b1, 1'b0, 1'b0);

        // Randomized frames against the frame-rule model.
        for (int i = 0; i < 20; i++) begin
            d      = 8'($urandom);
            p      = ($urandom_range(0, 1) == 1) ? 16 : 8;
            pen    = 1'($urandom_range(0, 1));
            ptyp   = 1'($urandom_range(0, 1));
            badpar = pen && ($urandom_range(0, 3) == 0);
            stopb  = ($urandom_range(0, 4) != 0);
            gap    = $urandom_range(0, 3);
            send_frame(d, p, pen, ptyp, badpar, stopb, gap,
                       stopb && !badpar, badpar, !stopb);
        end

        repeat (6) begin @(negedge CLK); RX_IN = 1'b1; sampled_bit = 1'b1; end
        chk("pending_pulses", 32'(exp_pulse.num()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
